spi_tx_serializer: RTL and testbench
====================================

# spi_tx_serializer

Parametrised SPI transmit serializer, successor to the fixed 32-bit transmit controller. Accepts words of run-time length through a valid/ready handshake, shifts them out MSB- or LSB-first on an external bit-rate strobe, chains words gaplessly into one chip-select frame, and optionally appends a CRC word at frame end. It sits between the SPI TX FIFO/CRC unit and the pad-side SCLK generator, which supplies `bit_en`.

## Interface
- `MAX_W`, 32: maximum word length in bits; `s_data` width.
- `MIN_W`, 4: minimum word length; shorter requests are clamped up to this.
- `CRC_W`, 16: CRC word length, at most `MAX_W`.
- `LEN_W`, $clog2(MAX_W)+1: width of the length fields.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `bit_en` in 1: single-cycle strobe that ends the current bit period.
- `s_valid` in 1: word available.
- `s_ready` out 1: word accepted when `s_valid & s_ready`.
- `s_data` in MAX_W: word, right-justified; bits above the length are ignored.
- `s_len` in LEN_W: requested length, clamped to [MIN_W, MAX_W].
- `s_last` in 1: word is the last of its frame.
- `msb_first` in 1: bit order, sampled per word at accept.
- `crc_en` in 1: append CRC after this frame, sampled with the `s_last` word.
- `crc_data` in CRC_W: CRC value, sampled on the final strobe of the last data word.
- `sdo` out 1: serial data.
- `cs_n` out 1: frame enable, low while a frame is in progress.
- `busy` out 1: state != IDLE.
- `bit_idx` out LEN_W: 0-based index of the bit currently on `sdo`.
- `word_done` out 1: pulse, one data word finished.
- `frame_done` out 1: pulse, frame (including CRC) finished.
- `underrun` out 1: pulse, no word was available at a mid-frame boundary.

## Operation
- States: IDLE, DATA, WAIT, CRC.
- `s_ready` = (IDLE) | (WAIT) | (DATA & `bit_en` & final bit & !cur_last). The DATA term is combinational on `bit_en`.
- Accept loads the shift register, normalised so bit 0 leaves first. For MSB-first, bit-reverse the low `len` bits. It also latches the clamped `len`, `cur_last` and `crc_en`, and sets `bit_idx` to 0.
- IDLE + accept -> DATA.
- DATA, `bit_en`, `bit_idx` != len-1: advance to the next bit and increment `bit_idx`.
- DATA, `bit_en`, final bit:
  - pulse `word_done`.
  - If !cur_last and `s_valid`: accept and stay in DATA (gapless).
  - If !cur_last and !`s_valid`: pulse `underrun` and go to WAIT.
  - If cur_last and crc_en: load `crc_data` in the latched order, with length CRC_W, and go to CRC.
  - Otherwise: pulse `frame_done` and go to IDLE.
- WAIT: `sdo` = 0 and `cs_n` stays low. Accept -> DATA; the word then behaves exactly as one accepted in IDLE.
- CRC: shifts CRC_W bits. On the final strobe it pulses `frame_done` and goes to IDLE. `word_done` does not pulse for CRC.
- `bit_en` in IDLE or WAIT is ignored.
- Length clamp: `s_len` < MIN_W -> MIN_W; `s_len` > MAX_W -> MAX_W. This includes 0 -> MIN_W.

## Timing
- All outputs are registered except `s_ready`.
- Reset values: `sdo`=0, `cs_n`=1, `busy`=0, `bit_idx`=0, `word_done`=0, `frame_done`=0, `underrun`=0, state IDLE.
- Accept in cycle T:
  - `cs_n`=0, `busy`=1 and `sdo`=first bit from T+1.
  - Bit k is held on `sdo` from the cycle after strobe k-1, or T+1 for k=0, until strobe k.
  - A word of length N therefore consumes exactly N strobes.
- Gapless chaining: the next word's bit 0 appears the cycle after the previous word's final strobe.
- Pulses `word_done`, `frame_done` and `underrun` are high for exactly one cycle, the cycle after the causing strobe.
- On frame end, `cs_n`=1, `busy`=0 and `sdo`=0 in that same cycle.
- Earliest new accept is that same cycle, since `s_ready`=1 in IDLE.
- Minimum `cs_n`-high gap between frames is 1 cycle.
- `bit_en` on consecutive cycles is legal; the block supports one bit per clock.
- `rst` mid-frame: immediate return to reset values; the partial word is lost and no pulses are generated.

## Test plan
- MAX_W=32, `msb_first`=1, `s_len`=8, `s_data`=0xA5, `s_last`=1, `crc_en`=0, `bit_en` every 4 cycles -> `sdo` 1,0,1,0,0,1,0,1. `cs_n` low for 8 bit periods. One `word_done` and one `frame_done` after the 8th strobe.
- Same word with `msb_first`=0 -> `sdo` 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 read LSB-first: verify the order against 0x3C, expecting 0,0,1,1,1,1,0,0.
- Two words: 12-bit 0xABC (not last) held valid, then 32-bit 0xDEADBEEF (last), `bit_en` every cycle.
  - Expect 44 contiguous bits with no gap.
  - Expect `word_done` twice and `cs_n` low for exactly 44 cycles.
- Mid-frame underrun: first word not last, `s_valid` dropped at its final strobe.
  - Expect an `underrun` pulse, `sdo`=0 with `cs_n` low in WAIT.
  - A word presented 10 cycles later resumes shifting with `bit_idx`=0.
- CRC: last word 8-bit 0x81 with `crc_en`=1, `crc_data`=0x1D0F, CRC_W=16 -> 8 data bits then 16 CRC bits MSB-first. `frame_done` follows the 24th strobe.
- Clamp and reset: `s_len`=2 -> 4 bits sent; `s_len`=40 -> 32 bits sent. Asserting `rst` at bit 5 -> `cs_n`=1 and `sdo`=0 immediately, with no `frame_done`.

Source files
------------

// File: rtl/spi_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_serializer_if
// Purpose  : Word handshake bundle between the TX FIFO and the SPI serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_tx_serializer_if #(
    parameter int MAX_W = 32,
    parameter int LEN_W = $clog2(MAX_W) + 1
) ();
    logic             s_valid;
    logic             s_ready;
    logic [MAX_W-1:0] s_data;
    logic [LEN_W-1:0] s_len;
    logic             s_last;

    modport master (output s_valid, s_data, s_len, s_last, input  s_ready);
    modport slave  (input  s_valid, s_data, s_len, s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_serializer
// Purpose  : Variable-length SPI word serializer with gapless chaining and
//            optional end-of-frame CRC word, paced by an external bit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_serializer #(
    parameter int MAX_W = 32,
    parameter int MIN_W = 4,
    parameter int CRC_W = 16,
    parameter int LEN_W = $clog2(MAX_W) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    spi_tx_serializer_if.slave   s_if,
    input  logic                 msb_first,
    input  logic                 crc_en,
    input  logic [CRC_W-1:0]     crc_data,
    output logic                 sdo,
    output logic                 cs_n,
    output logic                 busy,
    output logic [LEN_W-1:0]     bit_idx,
    output logic                 word_done,
    output logic                 frame_done,
    output logic                 underrun
);

    localparam int               c_IDX_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [LEN_W-1:0] c_MIN_LEN = LEN_W'(MIN_W);
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_W);
    localparam logic [LEN_W-1:0] c_CRC_LEN = LEN_W'(CRC_W);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_WAIT = 2'd2,
        S_CRC  = 2'd3
    } state_t;

    // Normalise a word so that bit 0 is always the next bit on the wire.
    function automatic logic [MAX_W-1:0] f_order(input logic [MAX_W-1:0] d,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic             msb);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(len)) begin
                v[c_IDX_W'(i)] = msb ? d[c_IDX_W'(int'(len) - 1 - i)] : d[c_IDX_W'(i)];
            end
        end
        return v;
    endfunction

    state_t             r_state;
    logic [MAX_W-1:0]   r_shift;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_bit_idx;
    logic               r_cur_last;
    logic               r_crc_en;
    logic               r_msb_first;
    logic               r_sdo;
    logic               r_cs_n;
    logic               r_busy;
    logic               r_word_done;
    logic               r_frame_done;
    logic               r_underrun;

    state_t             w_nxt_state;
    logic [MAX_W-1:0]   w_nxt_shift;
    logic [LEN_W-1:0]   w_nxt_len;
    logic [LEN_W-1:0]   w_nxt_idx;
    logic               w_nxt_last;
    logic               w_nxt_crc_en;
    logic               w_nxt_msb;
    logic               w_word_done;
    logic               w_frame_done;
    logic               w_underrun;
    logic               w_load;
    logic               w_final;
    logic               w_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_clamped;

    assign w_final  = (r_bit_idx == (r_len - c_ONE));
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_WAIT) ||
                      ((r_state == S_DATA) && bit_en && w_final && !r_cur_last);
    assign w_accept = s_if.s_valid && w_ready;

    assign w_len_clamped = (s_if.s_len < c_MIN_LEN) ? c_MIN_LEN :
                           (s_if.s_len > c_MAX_LEN) ? c_MAX_LEN : s_if.s_len;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_shift  = r_shift;
        w_nxt_len    = r_len;
        w_nxt_idx    = r_bit_idx;
        w_nxt_last   = r_cur_last;
        w_nxt_crc_en = r_crc_en;
        w_nxt_msb    = r_msb_first;
        w_word_done  = 1'b0;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;
        w_load       = 1'b0;

        unique case (r_state)
            S_IDLE, S_WAIT: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_nxt_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    if (!w_final) begin
                        w_nxt_shift = r_shift >> 1;
                        w_nxt_idx   = r_bit_idx + c_ONE;
                    end else begin
                        w_word_done = 1'b1;
                        w_nxt_idx   = '0;
                        if (!r_cur_last) begin
                            if (s_if.s_valid) begin
                                w_load = 1'b1;
                            end else begin
                                w_underrun  = 1'b1;
                                w_nxt_state = S_WAIT;
                            end
                        end else if (r_crc_en) begin
                            // CRC goes out in the bit order of the frame's last word.
                            w_nxt_shift = f_order(MAX_W'(crc_data), c_CRC_LEN, r_msb_first);
                            w_nxt_len   = c_CRC_LEN;
                            w_nxt_state = S_CRC;
                        end else begin
                            w_frame_done = 1'b1;
                            w_nxt_state  = S_IDLE;
                        end
                    end
                end
            end
            S_CRC: begin
                if (bit_en) begin
                    if (!w_final) begin
                        w_nxt_shift = r_shift >> 1;
                        w_nxt_idx   = r_bit_idx + c_ONE;
                    end else begin
                        w_frame_done = 1'b1;
                        w_nxt_idx    = '0;
                        w_nxt_state  = S_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_nxt_shift  = f_order(s_if.s_data, w_len_clamped, msb_first);
            w_nxt_len    = w_len_clamped;
            w_nxt_idx    = '0;
            w_nxt_last   = s_if.s_last;
            w_nxt_crc_en = crc_en;
            w_nxt_msb    = msb_first;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_len        <= c_MIN_LEN;
            r_bit_idx    <= '0;
            r_cur_last   <= 1'b0;
            r_crc_en     <= 1'b0;
            r_msb_first  <= 1'b0;
            r_sdo        <= 1'b0;
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_shift      <= w_nxt_shift;
            r_len        <= w_nxt_len;
            r_bit_idx    <= w_nxt_idx;
            r_cur_last   <= w_nxt_last;
            r_crc_en     <= w_nxt_crc_en;
            r_msb_first  <= w_nxt_msb;
            // Line is driven only while shifting; WAIT and IDLE park it low.
            r_sdo        <= ((w_nxt_state == S_DATA) || (w_nxt_state == S_CRC)) ?
                            w_nxt_shift[0] : 1'b0;
            r_cs_n       <= (w_nxt_state == S_IDLE);
            r_busy       <= (w_nxt_state != S_IDLE);
            r_word_done  <= w_word_done;
            r_frame_done <= w_frame_done;
            r_underrun   <= w_underrun;
        end
    end

    assign s_if.s_ready = w_ready;
    assign sdo          = r_sdo;
    assign cs_n         = r_cs_n;
    assign busy         = r_busy;
    assign bit_idx      = r_bit_idx;
    assign word_done    = r_word_done;
    assign frame_done   = r_frame_done;
    assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_serializer
// Purpose  : Scoreboard bench for spi_tx_serializer: frame-level bit streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_serializer;

    localparam int c_MAX_W   = 32;
    localparam int c_MIN_W   = 4;
    localparam int c_CRC_W   = 16;
    localparam int c_LEN_W   = 6;
    localparam int c_TIMEOUT = 4000;

    typedef struct {
        logic [255:0] bits;
        int           nbits;
        int           nwords;
        int           cs_cycles;
    } frame_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              bit_en    = 1'b0;
    logic              msb_first = 1'b0;
    logic              crc_en    = 1'b0;
    logic [c_CRC_W-1:0] crc_data = '0;
    logic              sdo;
    logic              cs_n;
    logic              busy;
    logic [c_LEN_W-1:0] bit_idx;
    logic              word_done;
    logic              frame_done;
    logic              underrun;

    int          n_checks      = 0;
    int          n_fail        = 0;
    int          frames_pushed = 0;
    int          mon_frames    = 0;
    int          mon_underruns = 0;
    int          period        = 0;
    frame_t      exp_q[$];
    logic [31:0] wd[$];
    int          wl[$];
    logic        wm[$];

    spi_tx_serializer_if #(.MAX_W(c_MAX_W), .LEN_W(c_LEN_W)) bus ();

    spi_tx_serializer #(
        .MAX_W(c_MAX_W), .MIN_W(c_MIN_W), .CRC_W(c_CRC_W), .LEN_W(c_LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .s_if(bus),
        .msb_first(msb_first), .crc_en(crc_en), .crc_data(crc_data),
        .sdo(sdo), .cs_n(cs_n), .busy(busy), .bit_idx(bit_idx),
        .word_done(word_done), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        return (l < c_MIN_W) ? c_MIN_W : ((l > c_MAX_W) ? c_MAX_W : l);
    endfunction

    // Strobe generator: one bit_en pulse every 'period' cycles (0 = off).
    initial begin : strobe_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            bit_en = (period != 0) && ((cnt % period) == 0);
        end
    end

    // Monitor: gathers the wire bit at each strobe and scores whole frames.
    initial begin : monitor
        logic [255:0] got;
        int           nb;
        int           nw;
        int           ncs;
        bit           in_wait;
        frame_t       e;
        got = '0; nb = 0; nw = 0; ncs = 0; in_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (underrun) mon_underruns++;
            if (word_done) nw++;
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done got=1 exp=0");
                end else begin
                    e = exp_q.pop_front();
                    check("frame_nbits", nb, e.nbits);
                    n_checks++;
                    if (got !== e.bits) begin
                        n_fail++;
                        $display("FAIL frame_bits got=%h exp=%h", got, e.bits);
                    end
                    check("frame_words", nw, e.nwords);
                    if (e.cs_cycles >= 0) check("frame_cs_cycles", ncs, e.cs_cycles);
                end
                mon_frames++;
                got = '0; nb = 0; nw = 0; ncs = 0; in_wait = 1'b0;
            end else if (cs_n) begin
                got = '0; nb = 0; nw = 0; ncs = 0; in_wait = 1'b0;
            end else begin
                ncs++;
                if (underrun) in_wait = 1'b1;
                if (in_wait) begin
                    check("wait_sdo", sdo, 0);
                    if (bus.s_valid && bus.s_ready) in_wait = 1'b0;
                end else if (bit_en) begin
                    if (nb < 256) got = got | (256'(sdo) << nb);
                    nb++;
                end
            end
        end
    end

    task automatic new_frame();
        wd.delete();
        wl.delete();
        wm.delete();
    endtask

    task automatic add_word(input logic [31:0] d, input int l, input logic m);
        wd.push_back(d);
        wl.push_back(l);
        wm.push_back(m);
    endtask

    // Reference: concatenate each word's bits in its order, then the CRC.
    task automatic push_expected(input int nw, input logic ce, input logic [15:0] crc,
                                 input int cs_exp);
        frame_t      e;
        int          len;
        logic [31:0] t;
        e.bits = '0; e.nbits = 0; e.nwords = nw; e.cs_cycles = cs_exp;
        for (int w = 0; w < nw; w++) begin
            len = clamp_len(wl[w]);
            for (int i = 0; i < len; i++) begin
                t = wd[w] >> (wm[w] ? (len - 1 - i) : i);
                e.bits = e.bits | (256'(t[0]) << e.nbits);
                e.nbits++;
            end
        end
        if (ce) begin
            for (int i = 0; i < c_CRC_W; i++) begin
                t = 32'(crc) >> (wm[nw-1] ? (c_CRC_W - 1 - i) : i);
                e.bits = e.bits | (256'(t[0]) << e.nbits);
                e.nbits++;
            end
        end
        exp_q.push_back(e);
        frames_pushed++;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [5:0] len, input logic last,
                             input logic m, input logic ce);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_len   = len;
        bus.s_last  = last;
        msb_first   = m;
        crc_en      = ce;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_ready && n < c_TIMEOUT);
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_frames();
        int n;
        n = 0;
        while (mon_frames < frames_pushed && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (mon_frames < frames_pushed) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout got=%0d exp=%0d", mon_frames, frames_pushed);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nw, input logic ce, input logic [15:0] crc,
                             input int cs_exp);
        push_expected(nw, ce, crc, cs_exp);
        crc_data = crc;
        for (int w = 0; w < nw; w++) begin
            send_word(wd[w], 6'(wl[w]), (w == nw - 1), wm[w], ce);
        end
        wait_frames();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int fc;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_len   = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_sdo", sdo, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_bit_idx", bit_idx, 0);
        check("rst_word_done", word_done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;

        // 0xA5 MSB-first, slow strobe
        period = 4;
        new_frame(); add_word(32'hA5, 8, 1'b1); run_frame(1, 1'b0, 16'h0, -1);
        // 0x3C LSB-first
        new_frame(); add_word(32'h3C, 8, 1'b0); run_frame(1, 1'b0, 16'h0, -1);

        // Gapless 12 + 32 bits at full rate: cs_n low for exactly 44 cycles
        period = 1;
        new_frame(); add_word(32'hABC, 12, 1'b1); add_word(32'hDEADBEEF, 32, 1'b1);
        run_frame(2, 1'b0, 16'h0, 44);

        // CRC appended after an 8-bit last word
        period = 3;
        new_frame(); add_word(32'h81, 8, 1'b1); run_frame(1, 1'b1, 16'h1D0F, -1);

        // Length clamps
        period = 2;
        new_frame(); add_word($urandom, 2, 1'b1);  run_frame(1, 1'b0, 16'h0, -1);
        new_frame(); add_word($urandom, 40, 1'b0); run_frame(1, 1'b0, 16'h0, -1);
        new_frame(); add_word($urandom, 0, 1'b1);  run_frame(1, 1'b0, 16'h0, -1);

        // Mid-frame underrun, resume 10 cycles later
        period = 2;
        new_frame(); add_word($urandom, 8, 1'b1); add_word($urandom, 12, 1'b0);
        push_expected(2, 1'b0, 16'h0, -1);
        crc_data = '0;
        send_word(wd[0], 6'd8, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!underrun && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("underrun_seen", underrun, 1);
        check("wait_cs_n", cs_n, 0);
        check("wait_busy", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        send_word(wd[1], 6'd12, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("resume_bit_idx", bit_idx, 0);
        check("resume_cs_n", cs_n, 0);
        wait_frames();

        // Asynchronous reset at bit 5: frame discarded, no frame_done
        period = 1;
        new_frame(); add_word($urandom, 16, 1'b1);
        send_word(wd[0], 6'd16, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (bit_idx != 6'd5 && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_bit5", bit_idx, 5);
        fc = mon_frames;
        #1 rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sdo", sdo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bit_idx", bit_idx, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_frame_done", mon_frames, fc);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            int          nw;
            logic        ce;
            logic [15:0] crc;
            period = int'($urandom_range(1, 3));
            nw     = int'($urandom_range(1, 4));
            ce     = 1'($urandom_range(0, 1));
            crc    = 16'($urandom);
            new_frame();
            for (int w = 0; w < nw; w++) begin
                add_word($urandom, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            end
            run_frame(nw, ce, crc, -1);
        end

        check("underrun_count", mon_underruns, 1);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
